sb_mac16: RTL and testbench



---
 rtl/mac16_pkg.sv | 38 +++
 rtl/mac16_addsub.sv | 60 ++++++
 rtl/sb_mac16.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_sb_mac16.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mac16_pkg.sv
// mac16_pkg: shared encodings and arithmetic helper for the sb_mac16 DSP slice.
//   - LOWERINPUT, CARRYSELECT and OUTPUT_SELECT encodings
//   - addsub16(): 16-bit add/subtract with carry-out or borrow-out
package mac16_pkg;

   // Adder Y operand select (top | bottom meaning).
   localparam logic [1:0] LOWER_AB   = 2'b00;  // A | B
   localparam logic [1:0] LOWER_FG   = 2'b01;  // F | G
   localparam logic [1:0] LOWER_H    = 2'b10;  // H[31:16] | H[15:0]
   localparam logic [1:0] LOWER_SEXT = 2'b11;  // {16{Zbot[15]}} | {16{B[15]}}

   // Carry-in select; 10 and 11 both pick the cascade/external carry.
   localparam logic [1:0] CARRY_ZERO = 2'b00;
   localparam logic [1:0] CARRY_ONE  = 2'b01;

   // Output half select.
   localparam logic [1:0] OUT_Z   = 2'b00;
   localparam logic [1:0] OUT_ACC = 2'b01;
   localparam logic [1:0] OUT_FG  = 2'b10;
   localparam logic [1:0] OUT_H   = 2'b11;

   // Returns {cout, z}. For subtract, z = x - y - cin and cout is the borrow.
   function automatic logic [16:0] addsub16(input logic [15:0] x,
                                            input logic [15:0] y,
                                            input logic        cin,
                                            input logic        sub);
      logic [16:0] sum;
      if (sub) begin
         // x - y - cin == x + ~y + ~cin; a missing carry-out means a borrow.
         sum = {1'b0, x} + {1'b0, ~y} + {16'h0000, ~cin};
         return {~sum[16], sum[15:0]};
      end else begin
         sum = {1'b0, x} + {1'b0, y} + {16'h0000, cin};
         return sum;
      end
   endfunction

endpackage

// File: rtl/mac16_addsub.sv
// mac16_addsub: one 16-bit add/sub unit with its accumulator register.
//   clk, rst_n  clock, async active-low reset
//   ce          clock enable for the accumulator
//   sub         0 add, 1 subtract
//   cin         carry (add) / borrow (sub) in
//   orst        sync clear of accumulator
//   ohold       accumulator keeps its value
//   oload       accumulator loads ext instead of z
//   ext         C or D operand (X source when UPPER_INPUT=1, and load value)
//   y           already-selected Y operand
//   z           combinational adder result
//   acc         accumulator register
//   cout        carry (add) / borrow (sub) out
module mac16_addsub
   import mac16_pkg::*;
#(
   parameter int unsigned UPPER_INPUT = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ce,
   input  logic        sub,
   input  logic        cin,
   input  logic        orst,
   input  logic        ohold,
   input  logic        oload,
   input  logic [15:0] ext,
   input  logic [15:0] y,
   output logic [15:0] z,
   output logic [15:0] acc,
   output logic        cout
);

   logic [15:0] acc_q;
   logic [15:0] x;
   logic [16:0] res;

   assign x    = (UPPER_INPUT != 0) ? ext : acc_q;
   assign res  = addsub16(x, y, cin, sub);
   assign z    = res[15:0];
   assign cout = res[16];
   assign acc  = acc_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else if (ce) begin
         if (orst) begin
            acc_q <= '0;
         end else if (ohold) begin
            acc_q <= acc_q;
         end else if (oload) begin
            acc_q <= ext;
         end else begin
            acc_q <= z;
         end
      end
   end

endmodule

// File: rtl/sb_mac16.sv
// sb_mac16: behavioural iCE40 16x16 DSP slice.
//   clk, rst_n            clock, async active-low reset (clears every register)
//   ce                    clock enable for all registers
//   a, b, c, d            16-bit operands (a, b multiplier; c, d adder/load)
//   ahold..dhold          input register keeps its value
//   irsttop / irstbot     sync clear of A,C,F,top partials / B,D,G,bottom partial
//   orsttop / orstbot     sync clear of Q,H[31:16] / S,H[15:0]
//   oholdtop / oholdbot   accumulator keeps value
//   oloadtop / oloadbot   accumulator loads C / D
//   addsubtop / addsubbot 0 add, 1 subtract
//   ci                    external carry/borrow into the bottom unit
//   co                    top-unit carry/borrow out
//   o                     {top half, bottom half}
module sb_mac16
   import mac16_pkg::*;
#(
   parameter int unsigned A_REG                    = 0,
   parameter int unsigned B_REG                    = 0,
   parameter int unsigned C_REG                    = 0,
   parameter int unsigned D_REG                    = 0,
   parameter int unsigned A_SIGNED                 = 0,
   parameter int unsigned B_SIGNED                 = 0,
   parameter int unsigned MODE_8x8                 = 0,
   parameter int unsigned TOP_8x8_MULT_REG         = 0,
   parameter int unsigned BOT_8x8_MULT_REG         = 0,
   parameter int unsigned PIPELINE_16x16_MULT_REG1 = 0,
   parameter int unsigned PIPELINE_16x16_MULT_REG2 = 0,
   parameter int unsigned TOPADDSUB_UPPERINPUT     = 0,
   parameter int unsigned BOTADDSUB_UPPERINPUT     = 0,
   parameter logic [1:0]  TOPADDSUB_LOWERINPUT     = 2'b00,
   parameter logic [1:0]  BOTADDSUB_LOWERINPUT     = 2'b00,
   parameter logic [1:0]  TOPADDSUB_CARRYSELECT    = 2'b00,
   parameter logic [1:0]  BOTADDSUB_CARRYSELECT    = 2'b00,
   parameter logic [1:0]  TOPOUTPUT_SELECT         = 2'b00,
   parameter logic [1:0]  BOTOUTPUT_SELECT         = 2'b00
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ce,
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic [15:0] c,
   input  logic [15:0] d,
   input  logic        ahold,
   input  logic        bhold,
   input  logic        chold,
   input  logic        dhold,
   input  logic        irsttop,
   input  logic        irstbot,
   input  logic        orsttop,
   input  logic        orstbot,
   input  logic        oholdtop,
   input  logic        oholdbot,
   input  logic        oloadtop,
   input  logic        oloadbot,
   input  logic        addsubtop,
   input  logic        addsubbot,
   input  logic        ci,
   output logic        co,
   output logic [31:0] o
);

   // ---------------- input registers ----------------
   logic [15:0] a_q, b_q, c_q, d_q;
   logic [15:0] a_r, b_r, c_r, d_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q <= '0;
         c_q <= '0;
      end else if (ce) begin
         if (irsttop) begin
            a_q <= '0;
            c_q <= '0;
         end else begin
            if (!ahold) a_q <= a;
            if (!chold) c_q <= c;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b_q <= '0;
         d_q <= '0;
      end else if (ce) begin
         if (irstbot) begin
            b_q <= '0;
            d_q <= '0;
         end else begin
            if (!bhold) b_q <= b;
            if (!dhold) d_q <= d;
         end
      end
   end

   assign a_r = (A_REG != 0) ? a_q : a;
   assign b_r = (B_REG != 0) ? b_q : b;
   assign c_r = (C_REG != 0) ? c_q : c;
   assign d_r = (D_REG != 0) ? d_q : d;

   // ---------------- multiplier ----------------
   // High bytes carry the operand sign; low bytes are always unsigned.
   logic               a_sx, b_sx;
   logic signed [15:0] a_hi16, b_hi16;
   logic signed [23:0] a_hi24, b_hi24, a_lo24, b_lo24;
   logic        [15:0] f_c, g_c;
   logic signed [23:0] x1_c, x2_c;

   assign a_sx   = (A_SIGNED != 0) ? a_r[15] : 1'b0;
   assign b_sx   = (B_SIGNED != 0) ? b_r[15] : 1'b0;
   assign a_hi16 = {{8{a_sx}}, a_r[15:8]};
   assign b_hi16 = {{8{b_sx}}, b_r[15:8]};
   assign a_hi24 = {{16{a_sx}}, a_r[15:8]};
   assign b_hi24 = {{16{b_sx}}, b_r[15:8]};
   assign a_lo24 = {16'h0000, a_r[7:0]};
   assign b_lo24 = {16'h0000, b_r[7:0]};

   assign f_c  = a_hi16 * b_hi16;
   assign g_c  = {8'h00, a_r[7:0]} * {8'h00, b_r[7:0]};
   // Cross products only matter mod 2^24 since they are shifted by 8 into H.
   assign x1_c = a_hi24 * b_lo24;
   assign x2_c = a_lo24 * b_hi24;

   // F / G output registers.
   logic [15:0] f_q, g_q, f_r, g_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_q <= '0;
      end else if (ce) begin
         f_q <= irsttop ? 16'h0000 : f_c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         g_q <= '0;
      end else if (ce) begin
         g_q <= irstbot ? 16'h0000 : g_c;
      end
   end

   assign f_r = (TOP_8x8_MULT_REG != 0) ? f_q : f_c;
   assign g_r = (BOT_8x8_MULT_REG != 0) ? g_q : g_c;

   // First 16x16 pipeline stage: all four partials move together so the
   // cross terms stay aligned with the hi*hi / lo*lo terms of H.
   logic        [15:0] hh_q, ll_q, hh_r, ll_r;
   logic signed [23:0] x1_q, x2_q, x1_r, x2_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hh_q <= '0;
         x1_q <= '0;
         x2_q <= '0;
      end else if (ce) begin
         if (irsttop) begin
            hh_q <= '0;
            x1_q <= '0;
            x2_q <= '0;
         end else begin
            hh_q <= f_c;
            x1_q <= x1_c;
            x2_q <= x2_c;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ll_q <= '0;
      end else if (ce) begin
         ll_q <= irstbot ? 16'h0000 : g_c;
      end
   end

   assign hh_r = (PIPELINE_16x16_MULT_REG1 != 0) ? hh_q : f_c;
   assign ll_r = (PIPELINE_16x16_MULT_REG1 != 0) ? ll_q : g_c;
   assign x1_r = (PIPELINE_16x16_MULT_REG1 != 0) ? x1_q : x1_c;
   assign x2_r = (PIPELINE_16x16_MULT_REG1 != 0) ? x2_q : x2_c;

   logic [31:0] h_c, h_m, h_q, h_r;

   assign h_c = {hh_r, 16'h0000} + {x1_r, 8'h00} + {x2_r, 8'h00} + {16'h0000, ll_r};
   assign h_m = (MODE_8x8 != 0) ? 32'h0000_0000 : h_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_q <= '0;
      end else if (ce) begin
         h_q[31:16] <= orsttop ? 16'h0000 : h_m[31:16];
         h_q[15:0]  <= orstbot ? 16'h0000 : h_m[15:0];
      end
   end

   assign h_r = (PIPELINE_16x16_MULT_REG2 != 0) ? h_q : h_m;

   // ---------------- adders ----------------
   logic [15:0] y_top, y_bot, z_top, z_bot, acc_top, acc_bot;
   logic        cin_top, cin_bot, cout_top, cout_bot;

   always_comb begin
      y_bot = b_r;
      case (BOTADDSUB_LOWERINPUT)
         LOWER_AB:   y_bot = b_r;
         LOWER_FG:   y_bot = g_r;
         LOWER_H:    y_bot = h_r[15:0];
         LOWER_SEXT: y_bot = {16{b_r[15]}};
         default:    y_bot = b_r;
      endcase
   end

   // The top sign-extension source is the bottom result, so the top Y
   // operand depends combinationally on the bottom adder.
   always_comb begin
      y_top = a_r;
      case (TOPADDSUB_LOWERINPUT)
         LOWER_AB:   y_top = a_r;
         LOWER_FG:   y_top = f_r;
         LOWER_H:    y_top = h_r[31:16];
         LOWER_SEXT: y_top = {16{z_bot[15]}};
         default:    y_top = a_r;
      endcase
   end

   always_comb begin
      case (BOTADDSUB_CARRYSELECT)
         CARRY_ZERO: cin_bot = 1'b0;
         CARRY_ONE:  cin_bot = 1'b1;
         default:    cin_bot = ci;
      endcase
   end

   always_comb begin
      case (TOPADDSUB_CARRYSELECT)
         CARRY_ZERO: cin_top = 1'b0;
         CARRY_ONE:  cin_top = 1'b1;
         default:    cin_top = cout_bot;
      endcase
   end

   mac16_addsub #(
      .UPPER_INPUT(BOTADDSUB_UPPERINPUT)
   ) u_bot (
      .clk   (clk),
      .rst_n (rst_n),
      .ce    (ce),
      .sub   (addsubbot),
      .cin   (cin_bot),
      .orst  (orstbot),
      .ohold (oholdbot),
      .oload (oloadbot),
      .ext   (d_r),
      .y     (y_bot),
      .z     (z_bot),
      .acc   (acc_bot),
      .cout  (cout_bot)
   );

   mac16_addsub #(
      .UPPER_INPUT(TOPADDSUB_UPPERINPUT)
   ) u_top (
      .clk   (clk),
      .rst_n (rst_n),
      .ce    (ce),
      .sub   (addsubtop),
      .cin   (cin_top),
      .orst  (orsttop),
      .ohold (oholdtop),
      .oload (oloadtop),
      .ext   (c_r),
      .y     (y_top),
      .z     (z_top),
      .acc   (acc_top),
      .cout  (cout_top)
   );

   assign co = cout_top;

   // ---------------- output select ----------------
   always_comb begin
      o[31:16] = z_top;
      case (TOPOUTPUT_SELECT)
         OUT_Z:   o[31:16] = z_top;
         OUT_ACC: o[31:16] = acc_top;
         OUT_FG:  o[31:16] = f_r;
         OUT_H:   o[31:16] = h_r[31:16];
         default: o[31:16] = z_top;
      endcase
   end

   always_comb begin
      o[15:0] = z_bot;
      case (BOTOUTPUT_SELECT)
         OUT_Z:   o[15:0] = z_bot;
         OUT_ACC: o[15:0] = acc_bot;
         OUT_FG:  o[15:0] = g_r;
         OUT_H:   o[15:0] = h_r[15:0];
         default: o[15:0] = z_bot;
      endcase
   end

endmodule

// File: tb/tb_sb_mac16.sv
// tb_sb_mac16: directed self-checking bench for sb_mac16. Several instances
// with different configurations share one set of input drivers.
module tb_sb_mac16;

   logic        clk = 1'b0;
   logic        rst_n, ce;
   logic [15:0] a, b, c, d;
   logic        ahold, bhold, chold, dhold;
   logic        irsttop, irstbot, orsttop, orstbot;
   logic        oholdtop, oholdbot, oloadtop, oloadbot;
   logic        addsubtop, addsubbot, ci;

   logic [31:0] o_add, o_mul, o_acc, o_sgn, o_m8, o_m8fg;
   logic        co_add;
   logic        co_unused_mul, co_unused_acc, co_unused_sgn, co_unused_m8, co_unused_m8fg;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   // 32-bit adder: X = C/D, Y = A/B, bottom cin = CI, top cin = bottom cout.
   sb_mac16 #(
      .TOPADDSUB_UPPERINPUT(1), .BOTADDSUB_UPPERINPUT(1),
      .TOPADDSUB_CARRYSELECT(2'b11), .BOTADDSUB_CARRYSELECT(2'b11)
   ) u_add (
      .clk(clk), .rst_n(rst_n), .ce(ce), .a(a), .b(b), .c(c), .d(d),
      .ahold(ahold), .bhold(bhold), .chold(chold), .dhold(dhold),
      .irsttop(irsttop), .irstbot(irstbot), .orsttop(orsttop), .orstbot(orstbot),
      .oholdtop(oholdtop), .oholdbot(oholdbot), .oloadtop(oloadtop), .oloadbot(oloadbot),
      .addsubtop(addsubtop), .addsubbot(addsubbot), .ci(ci), .co(co_add), .o(o_add)
   );

   // Multiply-add: O = {C,D} + A*B.
   sb_mac16 #(
      .TOPADDSUB_UPPERINPUT(1), .BOTADDSUB_UPPERINPUT(1),
      .TOPADDSUB_LOWERINPUT(2'b10), .BOTADDSUB_LOWERINPUT(2'b10),
      .TOPADDSUB_CARRYSELECT(2'b10), .BOTADDSUB_CARRYSELECT(2'b00)
   ) u_mul (
      .clk(clk), .rst_n(rst_n), .ce(ce), .a(a), .b(b), .c(c), .d(d),
      .ahold(ahold), .bhold(bhold), .chold(chold), .dhold(dhold),
      .irsttop(irsttop), .irstbot(irstbot), .orsttop(orsttop), .orstbot(orstbot),
      .oholdtop(oholdtop), .oholdbot(oholdbot), .oloadtop(oloadtop), .oloadbot(oloadbot),
      .addsubtop(addsubtop), .addsubbot(addsubbot), .ci(ci), .co(co_unused_mul), .o(o_mul)
   );

   // Bottom accumulator S += B, shown on O[15:0].
   sb_mac16 #(
      .BOTADDSUB_UPPERINPUT(0), .BOTADDSUB_LOWERINPUT(2'b00), .BOTOUTPUT_SELECT(2'b01)
   ) u_acc (
      .clk(clk), .rst_n(rst_n), .ce(ce), .a(a), .b(b), .c(c), .d(d),
      .ahold(ahold), .bhold(bhold), .chold(chold), .dhold(dhold),
      .irsttop(irsttop), .irstbot(irstbot), .orsttop(orsttop), .orstbot(orstbot),
      .oholdtop(oholdtop), .oholdbot(oholdbot), .oloadtop(oloadtop), .oloadbot(oloadbot),
      .addsubtop(addsubtop), .addsubbot(addsubbot), .ci(ci), .co(co_unused_acc), .o(o_acc)
   );

   // Signed registered 16x16 product H.
   sb_mac16 #(
      .A_REG(1), .B_REG(1), .A_SIGNED(1), .B_SIGNED(1),
      .TOPOUTPUT_SELECT(2'b11), .BOTOUTPUT_SELECT(2'b11)
   ) u_sgn (
      .clk(clk), .rst_n(rst_n), .ce(ce), .a(a), .b(b), .c(c), .d(d),
      .ahold(ahold), .bhold(bhold), .chold(chold), .dhold(dhold),
      .irsttop(irsttop), .irstbot(irstbot), .orsttop(orsttop), .orstbot(orstbot),
      .oholdtop(oholdtop), .oholdbot(oholdbot), .oloadtop(oloadtop), .oloadbot(oloadbot),
      .addsubtop(addsubtop), .addsubbot(addsubbot), .ci(ci), .co(co_unused_sgn), .o(o_sgn)
   );

   // Same as u_sgn in 8x8 mode: H forced to zero.
   sb_mac16 #(
      .A_REG(1), .B_REG(1), .A_SIGNED(1), .B_SIGNED(1), .MODE_8x8(1),
      .TOPOUTPUT_SELECT(2'b11), .BOTOUTPUT_SELECT(2'b11)
   ) u_m8 (
      .clk(clk), .rst_n(rst_n), .ce(ce), .a(a), .b(b), .c(c), .d(d),
      .ahold(ahold), .bhold(bhold), .chold(chold), .dhold(dhold),
      .irsttop(irsttop), .irstbot(irstbot), .orsttop(orsttop), .orstbot(orstbot),
      .oholdtop(oholdtop), .oholdbot(oholdbot), .oloadtop(oloadtop), .oloadbot(oloadbot),
      .addsubtop(addsubtop), .addsubbot(addsubbot), .ci(ci), .co(co_unused_m8), .o(o_m8)
   );

   // 8x8 mode showing {F, G}.
   sb_mac16 #(
      .A_REG(1), .B_REG(1), .A_SIGNED(1), .B_SIGNED(1), .MODE_8x8(1),
      .TOPOUTPUT_SELECT(2'b10), .BOTOUTPUT_SELECT(2'b10)
   ) u_m8fg (
      .clk(clk), .rst_n(rst_n), .ce(ce), .a(a), .b(b), .c(c), .d(d),
      .ahold(ahold), .bhold(bhold), .chold(chold), .dhold(dhold),
      .irsttop(irsttop), .irstbot(irstbot), .orsttop(orsttop), .orstbot(orstbot),
      .oholdtop(oholdtop), .oholdbot(oholdbot), .oloadtop(oloadtop), .oloadbot(oloadbot),
      .addsubtop(addsubtop), .addsubbot(addsubbot), .ci(ci), .co(co_unused_m8fg), .o(o_m8fg)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; ce = 1'b1;
      a = '0; b = '0; c = '0; d = '0;
      ahold = 1'b0; bhold = 1'b0; chold = 1'b0; dhold = 1'b0;
      irsttop = 1'b0; irstbot = 1'b0; orsttop = 1'b0; orstbot = 1'b0;
      oholdtop = 1'b0; oholdbot = 1'b0; oloadtop = 1'b0; oloadbot = 1'b0;
      addsubtop = 1'b0; addsubbot = 1'b0; ci = 1'b0;

      // Reset state.
      #3;
      check("rst_o_sgn", o_sgn, 32'h0000_0000);
      check("rst_o_acc", o_acc, 32'h0000_0000);
      check("rst_co_add", {31'd0, co_add}, 32'd0);
      #4;
      rst_n = 1'b1;

      // 32-bit add with carry cascade.
      c = 16'h0001; d = 16'hFFFF; a = 16'h0000; b = 16'h0001; #1;
      check("add_o", o_add, 32'h0002_0000);
      check("add_co", {31'd0, co_add}, 32'd0);
      c = 16'h0000; d = 16'h0000; b = 16'h0000; ci = 1'b1; #1;
      check("add_ci", o_add, 32'h0000_0001);
      ci = 1'b0;

      // 32-bit subtract with borrow cascade.
      addsubtop = 1'b1; addsubbot = 1'b1;
      c = 16'h0002; d = 16'h0000; a = 16'h0000; b = 16'h0001; #1;
      check("sub_o", o_add, 32'h0001_FFFF);
      check("sub_co", {31'd0, co_add}, 32'd0);
      c = 16'h0000; #1;
      check("sub_wrap_o", o_add, 32'hFFFF_FFFF);
      check("sub_wrap_co", {31'd0, co_add}, 32'd1);
      addsubtop = 1'b0; addsubbot = 1'b0;

      // Multiply-add, unsigned.
      a = 16'h1234; b = 16'h5678; c = 16'h0000; d = 16'h0000; #1;
      check("mul_o", o_mul, 32'h0626_0060);
      c = 16'h0001; d = 16'hFFFF; #1;
      check("mul_add_o", o_mul, 32'h0628_005F);
      a = 16'hFFFF; b = 16'hFFFF; c = 16'h0000; d = 16'h0000; #1;
      check("mul_max_o", o_mul, 32'hFFFE_0001);

      // Bottom accumulator.
      orstbot = 1'b1; b = 16'h0005; tick();
      orstbot = 1'b0;
      check("acc_clr", {16'h0, o_acc[15:0]}, 32'h0000_0000);
      tick(); check("acc_5", {16'h0, o_acc[15:0]}, 32'h0000_0005);
      tick(); check("acc_10", {16'h0, o_acc[15:0]}, 32'h0000_000A);
      tick(); check("acc_15", {16'h0, o_acc[15:0]}, 32'h0000_000F);
      oholdbot = 1'b1; tick();
      check("acc_hold", {16'h0, o_acc[15:0]}, 32'h0000_000F);
      oholdbot = 1'b0; oloadbot = 1'b1; d = 16'h0100; tick();
      check("acc_load", {16'h0, o_acc[15:0]}, 32'h0000_0100);
      oloadbot = 1'b0; ce = 1'b0; tick(); tick();
      check("acc_ce0", {16'h0, o_acc[15:0]}, 32'h0000_0100);
      ce = 1'b1; tick();
      check("acc_resume", {16'h0, o_acc[15:0]}, 32'h0000_0105);

      // Asynchronous reset mid-accumulation.
      tick();
      check("acc_pre_rst", {16'h0, o_acc[15:0]}, 32'h0000_010A);
      #3; rst_n = 1'b0; #1;
      check("acc_async_rst", {16'h0, o_acc[15:0]}, 32'h0000_0000);
      #1; rst_n = 1'b1;
      tick(); check("acc_restart_5", {16'h0, o_acc[15:0]}, 32'h0000_0005);
      tick(); check("acc_restart_10", {16'h0, o_acc[15:0]}, 32'h0000_000A);

      // Signed registered product; registers currently hold A=FFFF, B=0005.
      a = 16'hFFFF; b = 16'h0002; #1;
      check("sgn_old", o_sgn, 32'hFFFF_FFFB);
      check("m8fg_old", o_m8fg, 32'h0000_04FB);
      tick();
      check("sgn_m1x2", o_sgn, 32'hFFFF_FFFE);
      check("m8_zero", o_m8, 32'h0000_0000);
      check("m8fg_m1x2", o_m8fg, 32'h0000_01FE);
      a = 16'h8000; b = 16'h8000; tick();
      check("sgn_min_sq", o_sgn, 32'h4000_0000);
      check("m8fg_min_sq", o_m8fg, 32'h4000_0000);
      a = 16'h7FFF; b = 16'hFFFF; tick();
      check("sgn_max_m1", o_sgn, 32'hFFFF_8001);
      check("m8fg_max_m1", o_m8fg, 32'hFF81_FE01);
      check("m8_zero2", o_m8, 32'h0000_0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
